int_stim_gen: RTL and testbench

//  Parametrised interrupt stimulus generator for the P7 CPU bench; drives the mips `interrupt` input.
//  Has N_CH independent channels. Each channel holds a target PC, a fire budget and an enable bit.
//  A channel asserts `interrupt` when macroscopic_pc matches its target.
//  The line drops when the handler writes the ack address, or when a timeout expires.

---
 rtl/int_stim_gen_if.sv | 31 +++
 rtl/int_stim_gen.sv | 161 ++++++++++++++++
 tb/tb_int_stim_gen.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/int_stim_gen_if.sv
// Bus bundle between the CPU bench (master) and the interrupt stimulus generator (slave).
// Carries the PC/ack snoop inputs, the channel config port and the interrupt outputs.
interface int_stim_gen_if #(
  parameter int N_CH = 4,
  parameter int CW   = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic [31:0]   macroscopic_pc;
  logic [31:0]   m_int_addr;
  logic [3:0]    m_int_byteen;
  logic          cfg_we;
  logic [CW-1:0] cfg_ch;
  logic          cfg_en;
  logic [31:0]   cfg_target_pc;
  logic [7:0]    cfg_fires;
  logic          interrupt;
  logic [CW-1:0] irq_ch;
  logic [15:0]   fired_total;
  logic          timeout_err;

  modport master (
    output macroscopic_pc, m_int_addr, m_int_byteen,
    output cfg_we, cfg_ch, cfg_en, cfg_target_pc, cfg_fires,
    input  interrupt, irq_ch, fired_total, timeout_err
  );

  modport slave (
    input  macroscopic_pc, m_int_addr, m_int_byteen,
    input  cfg_we, cfg_ch, cfg_en, cfg_target_pc, cfg_fires,
    output interrupt, irq_ch, fired_total, timeout_err
  );
endinterface

// File: rtl/int_stim_gen.sv
// Multi-channel interrupt stimulus generator: raises the CPU interrupt when the PC reaches a
// channel's target, drops it on an ack write, a timeout, or when the channel is disabled.
module int_stim_gen #(
  parameter int          N_CH     = 4,
  parameter logic [31:0] ACK_ADDR = 32'h00007f20,
  parameter logic [31:0] PC_MASK  = 32'hfffffffc,
  parameter int          TIMEOUT  = 1024,
  parameter int          CW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  int_stim_gen_if.slave bus
);

  typedef enum logic [0:0] {ST_IDLE, ST_ASSERT} state_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_irq_ch;
  logic [31:0]   r_hold;
  logic [15:0]   r_fired_total;
  logic          r_timeout_err;

  logic [N_CH-1:0] w_hit;
  logic [N_CH-1:0] w_en;
  logic            w_ack;
  logic            w_any_hit;
  logic [CW-1:0]   w_hit_ch;
  logic            w_start;
  logic            w_drop_ack;
  logic            w_drop_to;
  logic            w_drop_dis;
  logic            w_consume;

  assign w_ack = (|bus.m_int_byteen) && ((bus.m_int_addr & ~32'h3) == ACK_ADDR);

  // Lowest-index hit wins: scan downward so the last assignment is the smallest index.
  always_comb begin
    w_any_hit = |w_hit;
    w_hit_ch  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_hit_ch = CW'(i);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_drop_ack   = 1'b0;
    w_drop_to    = 1'b0;
    w_drop_dis   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_hit) begin
          w_state_next = ST_ASSERT;
          w_start      = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (w_ack) begin
          w_state_next = ST_IDLE;
          w_drop_ack   = 1'b1;
        end else if ((TIMEOUT != 0) && (r_hold == TO_LAST)) begin
          w_state_next = ST_IDLE;
          w_drop_to    = 1'b1;
        end else if (!w_en[r_irq_ch]) begin
          w_state_next = ST_IDLE;
          w_drop_dis   = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Ack and timeout both consume one fire of the asserting channel; a disable does not.
  assign w_consume = w_drop_ack | w_drop_to;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_irq_ch      <= '0;
      r_hold        <= '0;
      r_fired_total <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_irq_ch <= w_hit_ch;
        r_hold   <= '0;
      end else if (r_state == ST_ASSERT) begin
        r_hold <= r_hold + 32'd1;
      end
      if (w_drop_ack && (r_fired_total != 16'hffff)) begin
        r_fired_total <= r_fired_total + 16'd1;
      end
      if (w_drop_to) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic        r_en;
      logic        r_armed;
      logic [31:0] r_target;
      logic [7:0]  r_remaining;
      logic        w_sel;
      logic        w_dec;
      logic        w_match;

      // Out-of-range channel indices never match any gi, so such writes fall away.
      assign w_sel   = bus.cfg_we && (bus.cfg_ch == CW'(gi));
      assign w_dec   = w_consume && (r_irq_ch == CW'(gi));
      assign w_match = (bus.macroscopic_pc & PC_MASK) == (r_target & PC_MASK);
      assign w_hit[gi] = r_en && (r_remaining != 8'd0) && r_armed && w_match;
      assign w_en[gi]  = r_en;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_en        <= 1'b0;
          r_armed     <= 1'b1;
          r_target    <= '0;
          r_remaining <= '0;
        end else begin
          if (w_sel) begin
            r_en     <= bus.cfg_en;
            r_target <= bus.cfg_target_pc;
            r_armed  <= 1'b1;
            if (w_dec) begin
              r_remaining <= (bus.cfg_fires == 8'd0) ? 8'd0 : bus.cfg_fires - 8'd1;
              r_armed     <= 1'b0;
            end else begin
              r_remaining <= bus.cfg_fires;
            end
          end else if (w_dec) begin
            if (r_remaining != 8'd0) begin
              r_remaining <= r_remaining - 8'd1;
            end
            r_armed <= 1'b0;
          end
          // Leaving the target ends the visit, so the channel may fire again next time.
          if (!w_match) begin
            r_armed <= 1'b1;
          end
        end
      end
    end
  endgenerate

  assign bus.interrupt   = (r_state == ST_ASSERT);
  assign bus.irq_ch      = r_irq_ch;
  assign bus.fired_total = r_fired_total;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_int_stim_gen.sv
// Directed bench for int_stim_gen: stimulus queues expected interrupt edges with their cycle,
// and a negedge monitor pops and compares on every interrupt transition.
module tb_int_stim_gen;

  logic clk;
  logic reset;
  int   cyc;
  int   n_tests;
  int   n_fail;
  bit   mon_on;

  typedef struct {
    int          cyc;
    logic        lvl;
    logic [1:0]  ch;
    logic [15:0] tot;
    logic        terr;
  } ev_t;

  ev_t exp_q[$];

  int_stim_gen_if #(.N_CH(4), .CW(2)) bus ();

  int_stim_gen #(
    .N_CH    (4),
    .ACK_ADDR(32'h00007f20),
    .PC_MASK (32'hfffffffc),
    .TIMEOUT (8),
    .CW      (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input logic lvl, input logic [1:0] ch,
                      input logic [15:0] tot, input logic terr);
    ev_t e;
    e.cyc = c; e.lvl = lvl; e.ch = ch; e.tot = tot; e.terr = terr;
    exp_q.push_back(e);
  endtask

  task automatic cfg(input logic [1:0] ch, input logic en, input logic [31:0] tgt,
                     input logic [7:0] fires);
    bus.cfg_ch        = ch;
    bus.cfg_en        = en;
    bus.cfg_target_pc = tgt;
    bus.cfg_fires     = fires;
    bus.cfg_we        = 1'b1;
    tick(1);
    bus.cfg_we        = 1'b0;
  endtask

  task automatic ack(input logic [31:0] addr, input logic [3:0] be);
    bus.m_int_addr   = addr;
    bus.m_int_byteen = be;
    tick(1);
    bus.m_int_addr   = 32'h0;
    bus.m_int_byteen = 4'h0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Monitor: each interrupt transition is one transaction matched against the scoreboard.
  initial begin : monitor
    logic prev_int;
    ev_t  e;
    prev_int = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_on && (bus.interrupt !== prev_int)) begin
        $display("[TB] cyc %0d interrupt %0b irq_ch %0d fired_total %0d timeout_err %0b",
                 cyc, bus.interrupt, bus.irq_ch, bus.fired_total, bus.timeout_err);
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_edge: got interrupt=%0b at cyc %0d, required no change",
                   bus.interrupt, cyc);
        end else begin
          e = exp_q.pop_front();
          if ((cyc != e.cyc) || (bus.interrupt !== e.lvl) ||
              (e.lvl && (bus.irq_ch !== e.ch)) || (bus.fired_total !== e.tot) ||
              (bus.timeout_err !== e.terr)) begin
            n_fail++;
            $display("FAIL edge: got cyc=%0d int=%0b ch=%0d tot=%0d terr=%0b, required cyc=%0d int=%0b ch=%0d tot=%0d terr=%0b",
                     cyc, bus.interrupt, bus.irq_ch, bus.fired_total, bus.timeout_err,
                     e.cyc, e.lvl, e.ch, e.tot, e.terr);
          end
        end
        prev_int = bus.interrupt;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [15:0] tot;
    cyc = 0; n_tests = 0; n_fail = 0; mon_on = 1'b0;
    reset = 1'b1;
    bus.macroscopic_pc = 32'h1000;
    bus.m_int_addr     = 32'h0;
    bus.m_int_byteen   = 4'h0;
    bus.cfg_we         = 1'b0;
    bus.cfg_ch         = 2'd0;
    bus.cfg_en         = 1'b0;
    bus.cfg_target_pc  = 32'h0;
    bus.cfg_fires      = 8'd0;
    tick(2);
    check("rst_interrupt", 32'(bus.interrupt), 0);
    check("rst_irq_ch", 32'(bus.irq_ch), 0);
    check("rst_fired_total", 32'(bus.fired_total), 0);
    check("rst_timeout_err", 32'(bus.timeout_err), 0);
    reset = 1'b0;
    mon_on = 1'b1;
    tick(1);

    // T1: config and PC hit in the same cycle -> hit uses old config, fires one cycle later.
    bus.macroscopic_pc = 32'h3010;
    push(cyc + 2, 1'b1, 2'd0, 16'd0, 1'b0);
    cfg(2'd0, 1'b1, 32'h3010, 8'd1);
    tick(2);
    push(cyc + 1, 1'b0, 2'd0, 16'd1, 1'b0);
    ack(32'h7f20, 4'b0001);
    tick(2);
    bus.macroscopic_pc = 32'h1000; tick(2);
    bus.macroscopic_pc = 32'h3010; tick(3);
    bus.macroscopic_pc = 32'h1000; tick(1);
    check("t1_fired_total", 32'(bus.fired_total), 1);

    // T2: priority; ch1 fires twice before ch2 gets its turn.
    tot = 16'd1;
    cfg(2'd1, 1'b1, 32'h3020, 8'd2);
    cfg(2'd2, 1'b1, 32'h3020, 8'd1);
    for (int k = 0; k < 3; k++) begin
      bus.macroscopic_pc = 32'h3020;
      push(cyc + 1, 1'b1, (k < 2) ? 2'd1 : 2'd2, tot, 1'b0);
      tick(2);
      bus.macroscopic_pc = 32'h1000;
      tot = tot + 16'd1;
      push(cyc + 1, 1'b0, 2'd0, tot, 1'b0);
      ack(32'h7f20, 4'b1000);
    end
    bus.macroscopic_pc = 32'h3020; tick(3);
    bus.macroscopic_pc = 32'h1000; tick(1);

    // T3: PC held across ack -> no refire; exactly three fires via revisits.
    cfg(2'd0, 1'b1, 32'h3010, 8'd3);
    for (int k = 0; k < 3; k++) begin
      bus.macroscopic_pc = 32'h3010;
      push(cyc + 1, 1'b1, 2'd0, tot, 1'b0);
      tick(2);
      tot = tot + 16'd1;
      push(cyc + 1, 1'b0, 2'd0, tot, 1'b0);
      ack(32'h7f20, 4'b0010);
      tick(3);
      bus.macroscopic_pc = 32'h1000; tick(1);
    end
    bus.macroscopic_pc = 32'h3012; tick(3);
    bus.macroscopic_pc = 32'h1000; tick(1);
    check("t3_fired_total", 32'(bus.fired_total), 7);

    // T4: no ack -> high exactly 8 cycles, timeout_err set, total unchanged.
    cfg(2'd3, 1'b1, 32'h3040, 8'd2);
    bus.macroscopic_pc = 32'h3040;
    push(cyc + 1, 1'b1, 2'd3, 16'd7, 1'b0);
    push(cyc + 9, 1'b0, 2'd3, 16'd7, 1'b1);
    tick(12);
    bus.macroscopic_pc = 32'h1000; tick(1);
    check("t4_timeout_err", 32'(bus.timeout_err), 1);
    check("t4_fired_total", 32'(bus.fired_total), 7);

    // T5: ignored acks (idle, wrong address, no byte enables), then a masked-address ack.
    ack(32'h7f20, 4'b0001);
    tick(1);
    bus.macroscopic_pc = 32'h3040;
    push(cyc + 1, 1'b1, 2'd3, 16'd7, 1'b1);
    tick(1);
    ack(32'h7f24, 4'b1111);
    ack(32'h7f20, 4'b0000);
    push(cyc + 1, 1'b0, 2'd3, 16'd8, 1'b1);
    ack(32'h7f22, 4'b0100);
    tick(1);
    bus.macroscopic_pc = 32'h1000; tick(1);
    check("t5_fired_total", 32'(bus.fired_total), 8);

    // T6a: disable the asserting channel -> drop one cycle after the write lands.
    cfg(2'd2, 1'b1, 32'h3060, 8'd5);
    bus.macroscopic_pc = 32'h3060;
    push(cyc + 1, 1'b1, 2'd2, 16'd8, 1'b1);
    tick(1);
    push(cyc + 2, 1'b0, 2'd2, 16'd8, 1'b1);
    cfg(2'd2, 1'b0, 32'h3060, 8'd5);
    tick(3);
    bus.macroscopic_pc = 32'h1000; tick(1);

    // T6b: enabled reload to zero fires keeps the line up; ack still counts, no refire later.
    cfg(2'd1, 1'b1, 32'h3070, 8'd3);
    bus.macroscopic_pc = 32'h3070;
    push(cyc + 1, 1'b1, 2'd1, 16'd8, 1'b1);
    tick(1);
    cfg(2'd1, 1'b1, 32'h3070, 8'd0);
    push(cyc + 1, 1'b0, 2'd1, 16'd9, 1'b1);
    ack(32'h7f20, 4'b1111);
    bus.macroscopic_pc = 32'h1000; tick(1);
    bus.macroscopic_pc = 32'h3070; tick(3);
    bus.macroscopic_pc = 32'h1000; tick(1);

    // T6c: reset while asserting clears everything including the sticky error.
    cfg(2'd0, 1'b1, 32'h3080, 8'd1);
    bus.macroscopic_pc = 32'h3080;
    push(cyc + 1, 1'b1, 2'd0, 16'd9, 1'b1);
    tick(1);
    reset = 1'b1;
    push(cyc + 1, 1'b0, 2'd0, 16'd0, 1'b0);
    tick(1);
    check("rst2_interrupt", 32'(bus.interrupt), 0);
    check("rst2_irq_ch", 32'(bus.irq_ch), 0);
    check("rst2_fired_total", 32'(bus.fired_total), 0);
    check("rst2_timeout_err", 32'(bus.timeout_err), 0);
    reset = 1'b0;
    tick(4);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
